serial_adder_ctrl: RTL
======================

// Module: serial_adder_ctrl
// PURPOSE
//   Bit-serial addition controller. Sequences one external 1-bit full adder
//   (Adder1bit) over a WIDTH-bit operand pair, LSB first, one bit per clock.
//   Holds the running carry and the partial sum, and reports the result with a
//   start/busy/done handshake. Sits between a requester and the shared adder cell.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>=2); bit counter is $clog2(WIDTH+1) bits
// PORTS
//   clk       in   1      single clock, rising edge
//   rst_n     in   1      synchronous reset, active-low
//   start     in   1      request; sampled only when busy==0
//   a         in   WIDTH  operand A, latched on accepted start
//   b         in   WIDTH  operand B, latched on accepted start
//   cin       in   1      carry-in, latched on accepted start
//   add_a     out  1      to adder A  = current bit of latched A
//   add_b     out  1      to adder B  = current bit of latched B
//   add_cin   out  1      to adder Cin = carry register
//   add_s     in   1      from adder S
//   add_cout  in   1      from adder Cout
//   busy      out  1      high while in RUN
//   done      out  1      one-cycle pulse: sum/cout valid and newly updated
//   sum       out  WIDTH  result, held until the next completed operation
//   cout      out  1      final carry, held alongside sum
// BEHAVIOUR
//   - Reset (rst_n==0 at a rising edge): state=IDLE; busy=0, done=0, sum=0,
//     cout=0; shift regs, carry, and counter cleared. Takes priority over
//     everything, including mid-RUN: the operation is aborted and no done is issued.
//   - FSM states IDLE, RUN, DONE:
//     IDLE: start==1 -> load sh_a=a, sh_b=b, carry=cin, cnt=0, go RUN.
//     RUN : each edge: carry<=add_cout; sh_s<={add_s, sh_s[WIDTH-1:1]};
//           sh_a, sh_b shift right by 1; cnt<=cnt+1. When cnt==WIDTH-1,
//           go DONE and write sum<={add_s, sh_s[WIDTH-1:1]}, cout<=add_cout.
//     DONE: done=1 for exactly this cycle. start==1 -> accept as in IDLE
//           (back-to-back, go RUN); otherwise go IDLE.
//   - add_a=sh_a[0], add_b=sh_b[0], add_cin=carry (combinational from regs).
//     The adder is purely combinational; its add_s/add_cout are captured on the
//     same edge.
//   - Latency: start sampled at edge E0 -> RUN for edges E1..EWIDTH -> done=1
//     during the cycle after EWIDTH. Throughput: one op per WIDTH+1 cycles.
//   - busy = (state==RUN). start is ignored while busy; operand changes
//     during RUN have no effect.
//   - sum/cout change only at the edge entering DONE; they hold through
//     IDLE and the next RUN.
//   - Result = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the full sum.
//     No overflow flag.
// TESTING (bench instantiates Adder1bit as the datapath, WIDTH=8)
//   - a=8'h5A, b=8'h3C, cin=0, start for 1 cycle -> busy for 8 cycles, done
//     pulse on cycle 9, sum=8'h96, cout=0
//   - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1
//     (carry ripples through all 8 bits)
//   - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1; then a=0, b=0, cin=0 ->
//     sum=8'h00, cout=0
//   - start re-asserted with new operands on cycles 3..5 of a RUN -> ignored;
//     first result unchanged, no extra done
//   - rst_n=0 for 1 cycle on RUN cycle 4 -> next cycle busy=0, done=0, sum=0,
//     cout=0; no done pulse
//   - start held high in the DONE cycle with a=8'h01, b=8'h01 -> busy the next
//     cycle; second done 9 cycles later with sum=8'h02; exhaustive random
//     compare vs a+b+cin

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// serial_adder_ctrl : bit-serial add sequencer driving an external 1-bit adder
// Rev 1.0
// ============================================================================
`default_nettype none

module Adder1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             add_a,
  output logic             add_b,
  output logic             add_cin,
  input  logic             add_s,
  input  logic             add_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_last;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-1:0] r_sh_s;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  assign w_last = (r_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // sh_s is not cleared on load: WIDTH shifts fully overwrite it before use.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh_a  <= '0;
      r_sh_b  <= '0;
      r_sh_s  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_load) begin
      r_sh_a  <= a;
      r_sh_b  <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_sh_a  <= r_sh_a >> 1;
      r_sh_b  <= r_sh_b >> 1;
      r_sh_s  <= {add_s, r_sh_s[WIDTH-1:1]};
      r_carry <= add_cout;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= {add_s, r_sh_s[WIDTH-1:1]};
        r_cout <= add_cout;
      end
    end
  end

  assign add_a   = r_sh_a[0];
  assign add_b   = r_sh_b[0];
  assign add_cin = r_carry;
  assign sum     = r_sum;
  assign cout    = r_cout;

endmodule

`default_nettype wire
